led_step_sequencer: RTL and testbench

LED_STEP_SEQUENCER -- requirements
Module: led_step_sequencer

---
 rtl/led_step_sequencer.sv | 111 +++++++++++
 tb/tb_led_step_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_step_sequencer.sv
// Stepped 16-LED pattern generator (HOLD/BLINK/RUN/BOUNCE) with power-of-two step periods.
// Define LED_SEQ_STEP_CNT_EN to add the step_cnt output counting every step cycle.
module led_step_sequencer #(
  parameter int FAST_N = 25,
  parameter int SLOW_N = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        speed,
  input  logic        mode_valid,
  input  logic [1:0]  mode_req,
  output logic        mode_ack,
  output logic [1:0]  mode,
`ifdef LED_SEQ_STEP_CNT_EN
  output logic [15:0] step_cnt,
`endif
  output logic [15:0] led
);

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_RUN    = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  logic [SLOW_N-1:0] prescaler;
  logic [1:0]        pending;
  logic              pending_valid;
  logic              dir_left;
  logic              fast_tick;
  logic              slow_tick;
  logic              step;
  logic              apply;

  assign fast_tick = &prescaler[FAST_N-1:0];
  assign slow_tick = &prescaler;
  assign step      = en & (speed ? slow_tick : fast_tick);
  assign apply     = step & pending_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler     <= '0;
      led           <= 16'hFFFF;
      mode          <= MODE_HOLD;
      dir_left      <= 1'b1;
      pending       <= MODE_HOLD;
      pending_valid <= 1'b0;
      mode_ack      <= 1'b0;
    end else begin
      prescaler <= prescaler + SLOW_N'(1);
      mode_ack  <= 1'b0;

      // A new request always wins the pending register, even on the apply edge.
      if (mode_valid) begin
        pending       <= mode_req;
        pending_valid <= 1'b1;
      end else if (apply) begin
        pending_valid <= 1'b0;
      end

      if (apply) begin
        mode     <= pending;
        mode_ack <= (pending != mode);
        case (pending)
          MODE_BLINK:  led <= 16'hFFFF;
          MODE_RUN:    led <= 16'h0001;
          MODE_BOUNCE: begin
            led      <= 16'h0001;
            dir_left <= 1'b1;
          end
          default:     led <= led;
        endcase
      end else if (step) begin
        case (mode)
          MODE_BLINK: led <= ~led;
          MODE_RUN:   led <= {led[14:0], led[15]};
          MODE_BOUNCE: begin
            // Reversal and the move away from the end happen on the same step.
            if (dir_left) begin
              if (led == 16'h8000) begin
                dir_left <= 1'b0;
                led      <= {1'b0, led[15:1]};
              end else begin
                led <= {led[14:0], 1'b0};
              end
            end else begin
              if (led == 16'h0001) begin
                dir_left <= 1'b1;
                led      <= {led[14:0], 1'b0};
              end else begin
                led <= {1'b0, led[15:1]};
              end
            end
          end
          default: led <= led;
        endcase
      end
    end
  end

`ifdef LED_SEQ_STEP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= 16'h0000;
    end else if (step) begin
      step_cnt <= step_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed bench for led_step_sequencer with FAST_N=2, SLOW_N=4 (fast step every 4, slow every 16 cycles).
module tb_led_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        speed = 1'b0;
  logic        mode_valid = 1'b0;
  logic [1:0]  mode_req = 2'd0;
  logic        mode_ack;
  logic [1:0]  mode;
  logic [15:0] led;
`ifdef LED_SEQ_STEP_CNT_EN
  logic [15:0] step_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;  // edges since reset release; edge k sees prescaler = k mod 16

  led_step_sequencer #(.FAST_N(2), .SLOW_N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .speed      (speed),
    .mode_valid (mode_valid),
    .mode_req   (mode_req),
    .mode_ack   (mode_ack),
    .mode       (mode),
`ifdef LED_SEQ_STEP_CNT_EN
    .step_cnt   (step_cnt),
`endif
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Advance so that the next tick lands exactly on a fast step edge, then take it.
  task automatic step_once();
    while ((cyc % 4) != 3) tick();
    tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [15:0] e_led, input logic [1:0] e_mode,
                           input logic e_ack);
    chk({tag, ".led"}, led, e_led);
    chk({tag, ".mode"}, {14'd0, mode}, {14'd0, e_mode});
    chk({tag, ".ack"}, {15'd0, mode_ack}, {15'd0, e_ack});
  endtask

  initial begin
    logic [15:0] exp_led;
    int pos;

    // Reset state
    tick();
    tick();
    chk_state("reset", 16'hFFFF, 2'd0, 1'b0);
`ifdef LED_SEQ_STEP_CNT_EN
    chk("reset.step_cnt", step_cnt, 16'h0000);
`endif
    rst = 1'b0;
    cyc = 0;

    // Enabled HOLD, no requests: 12 edges contain 3 fast steps
    en = 1'b1;
    speed = 1'b0;
    repeat (12) tick();
    chk_state("hold_idle", 16'hFFFF, 2'd0, 1'b0);
`ifdef LED_SEQ_STEP_CNT_EN
    chk("hold_idle.step_cnt", step_cnt, 16'h0003);
`endif

    // RUN request at edge 12, applied at edge 15
    mode_valid = 1'b1;
    mode_req = 2'd2;
    tick();
    mode_valid = 1'b0;
    tick();
    tick();
    chk_state("run_wait", 16'hFFFF, 2'd0, 1'b0);
    tick();
    chk_state("run_apply", 16'h0001, 2'd2, 1'b1);
    tick();
    chk({"run_ack_drop"}, {15'd0, mode_ack}, 16'h0000);
    for (int i = 1; i <= 16; i++) begin
      step_once();
      exp_led = 16'h0001 << (i % 16);
      chk($sformatf("run_step%0d", i), led, exp_led);
    end

    // BOUNCE from 0x0001 over 30 steps
    mode_valid = 1'b1;
    mode_req = 2'd3;
    tick();
    mode_valid = 1'b0;
    step_once();
    chk_state("bounce_apply", 16'h0001, 2'd3, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      step_once();
      pos = (i <= 15) ? i : 30 - i;
      exp_led = 16'h0001 << pos;
      chk($sformatf("bounce_step%0d", i), led, exp_led);
    end

    // Request coinciding with a step: step applies the older pending value
    mode_valid = 1'b1;
    mode_req = 2'd2;
    tick();
    mode_valid = 1'b0;
    while ((cyc % 4) != 3) tick();
    mode_valid = 1'b1;
    mode_req = 2'd1;
    tick();
    mode_valid = 1'b0;
    chk_state("collide_first", 16'h0001, 2'd2, 1'b1);
    step_once();
    chk_state("collide_second", 16'hFFFF, 2'd1, 1'b1);

    // BLINK at slow speed, then fast
    speed = 1'b1;
    while ((cyc % 16) != 15) tick();
    tick();
    chk("blink_slow1", led, 16'h0000);
    repeat (15) tick();
    chk("blink_slow_hold", led, 16'h0000);
    tick();
    chk("blink_slow2", led, 16'hFFFF);
    speed = 1'b0;
    repeat (3) tick();
    chk("blink_fast_hold", led, 16'hFFFF);
    tick();
    chk("blink_fast1", led, 16'h0000);
    step_once();
    chk("blink_fast2", led, 16'hFFFF);

    // Same-mode request: reload (no toggle), no ack
    mode_valid = 1'b1;
    mode_req = 2'd1;
    tick();
    mode_valid = 1'b0;
    step_once();
    chk_state("same_mode", 16'hFFFF, 2'd1, 1'b0);

    // en=0 freezes everything; pending request applied on first enabled step
    en = 1'b0;
    mode_valid = 1'b1;
    mode_req = 2'd2;
    tick();
    mode_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_state($sformatf("frozen%0d", i), 16'hFFFF, 2'd1, 1'b0);
    end
    en = 1'b1;
    step_once();
    chk_state("unfreeze_apply", 16'h0001, 2'd2, 1'b1);

    // Async reset mid-BOUNCE with a request pending
    mode_valid = 1'b1;
    mode_req = 2'd3;
    tick();
    mode_valid = 1'b0;
    step_once();
    step_once();
    chk_state("bounce_pre_rst", 16'h0002, 2'd3, 1'b0);
    mode_valid = 1'b1;
    mode_req = 2'd1;
    tick();
    mode_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_state("async_rst", 16'hFFFF, 2'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    repeat (4) tick();
    chk_state("post_rst_step", 16'hFFFF, 2'd0, 1'b0);
    tick();
    chk_state("post_rst_noack", 16'hFFFF, 2'd0, 1'b0);
`ifdef LED_SEQ_STEP_CNT_EN
    chk("post_rst.step_cnt", step_cnt, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
